// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the serial packed-BCD adder/subtractor:
// FSM state encodings, BCD digit constants and the nines-complement helper.
package bcd_serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Largest legal BCD digit and the correction added when a digit sum overflows it.
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    // Nines complement of one digit, wrapping mod 16 so invalid digits stay deterministic.
    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_serial_adder_digit.sv
// Single-digit decimal adder: digit = d + e + ci with the +6 correction when
// the binary sum exceeds 9. Invalid input digits pass through the same rule.
module bcd_digit_add
    import bcd_serial_adder_pkg::*;
(
    input  logic [3:0] d_i,
    input  logic [3:0] e_i,
    input  logic       ci_i,
    output logic [3:0] digit_o,
    output logic       co_o
);

    logic [4:0] t;

    // Binary digit sum followed by the decimal adjust.
    always_comb begin
        t       = {1'b0, d_i} + {1'b0, e_i} + {4'b0000, ci_i};
        digit_o = t[3:0];
        co_o    = 1'b0;
        if (t > {1'b0, BCD_MAX}) begin
            digit_o = t[3:0] + BCD_ADJ;
            co_o    = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder/subtractor, one digit per clock through a
// single shared digit adder. Subtraction is a + nines(b) + 1 (ten's complement).
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int NDIGITS = 4,
    parameter int IDXW    = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic                 cin,
    input  logic [4*NDIGITS-1:0] a,
    input  logic [4*NDIGITS-1:0] b,
    output logic [4*NDIGITS-1:0] sum,
    output logic                 cout,
    output logic                 neg,
    output logic                 err,
    output logic                 busy,
    output logic                 done
);

    localparam int W = 4 * NDIGITS;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q,   idx_d;
    logic [W-1:0]    a_q,     a_d;
    logic [W-1:0]    b_q,     b_d;
    logic            sub_q,   sub_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    sum_q,   sum_d;
    logic            cout_q,  cout_d;
    logic            neg_q,   neg_d;
    logic            err_q,   err_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;

    logic [3:0] a_dig;
    logic [3:0] b_dig;
    logic [3:0] e_dig;
    logic [3:0] res_dig;
    logic       res_co;

    // Pick the current digit of each latched operand and apply the subtract-mode complement.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        e_dig = sub_q ? nines_comp(b_dig) : b_dig;
    end

    bcd_digit_add u_digit (
        .d_i     (a_dig),
        .e_i     (e_dig),
        .ci_i    (carry_q),
        .digit_o (res_dig),
        .co_o    (res_co)
    );

    // Next-state and register-update logic for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        neg_d   = neg_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            RUN: begin
                for (int unsigned i = 0; i < NDIGITS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        sum_d[4*i +: 4] = res_dig;
                    end
                end
                carry_d = res_co;
                err_d   = err_q | (a_dig > BCD_MAX) | (b_dig > BCD_MAX);
                idx_d   = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cout_d  = res_co;
                    neg_d   = sub_q & ~res_co;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign neg  = neg_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (NDIGITS=4): expectations come from a
// decimal integer model or hand-derived constants, queued at start and
// checked when done pulses.
module tb_bcd_serial_adder;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
    logic        neg;
    logic        err;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        neg;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    bcd_serial_adder #(.NDIGITS(ND), .IDXW(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .neg   (neg),
        .err   (err),
        .busy  (busy),
        .done  (done)
    );

    function automatic int bcd2int(input logic [15:0] v);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n);
        logic [15:0] r;
        int m = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Decimal reference for valid operands.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic s, input logic c);
        exp_t e;
        int xi = bcd2int(x);
        int yi = bcd2int(y);
        int r;
        if (s) begin
            r      = xi - yi + 10000;
            e.cout = (xi >= yi);
            e.neg  = ~e.cout;
        end else begin
            r      = xi + yi + int'(c);
            e.cout = (r >= 10000);
            e.neg  = 1'b0;
        end
        e.sum = int2bcd(r % 10000);
        e.err = 1'b0;
        return e;
    endfunction

    // Present an operation at a negedge, hold start one cycle; returns at the
    // negedge just after the accepting edge.
    task automatic drive_start(input logic [15:0] x, input logic [15:0] y,
                               input logic s, input logic c);
        @(negedge clk);
        a = x; b = y; sub = s; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; cyc counts negedges since the accept edge.
    task automatic wait_done(output int cyc, output int bcnt, output bit to);
        cyc  = 1;
        bcnt = (busy === 1'b1) ? 1 : 0;
        to   = 1'b0;
        while (done !== 1'b1) begin
            if (cyc >= 30) begin
                to = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) bcnt++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({sum, cout, neg, err, busy, done} !== 21'd0) begin
            bad++;
            $display("FAIL reset_state act=%h req=0", {sum, cout, neg, err, busy, done});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [15:0] xa[3] = '{16'h1234, 16'h9999, 16'h9999};
        logic [15:0] xb[3] = '{16'h5678, 16'h0001, 16'h0001};
        logic        xc[3] = '{1'b0, 1'b0, 1'b1};
        exp_t fixed[3] = '{{16'h6912, 1'b0, 1'b0, 1'b0},
                           {16'h0000, 1'b1, 1'b0, 1'b0},
                           {16'h0001, 1'b1, 1'b0, 1'b0}};
        for (int n = 0; n < 9; n++) begin
            logic [15:0] x, y;
            logic c;
            exp_t e, obs;
            int cyc, bcnt;
            bit to;
            if (n < 3) begin
                x = xa[n]; y = xb[n]; c = xc[n]; e = fixed[n];
            end else begin
                x = int2bcd(int'($urandom_range(0, 9999)));
                y = int2bcd(int'($urandom_range(0, 9999)));
                c = 1'($urandom_range(0, 1));
                e = model(x, y, 1'b0, c);
            end
            sb.push_back(e);
            drive_start(x, y, 1'b0, c);
            wait_done(cyc, bcnt, to);
            total++;
            if (to) begin
                bad++;
                $display("FAIL add_timeout op=%0d no done within %0d cycles", n, cyc);
                void'(sb.pop_front());
                continue;
            end
            e   = sb.pop_front();
            obs = {sum, cout, neg, err};
            if (obs !== e) begin
                bad++;
                $display("FAIL add_result a=%h b=%h cin=%b act=%h/%b/%b/%b req=%h/%b/%b/%b",
                         x, y, c, obs.sum, obs.cout, obs.neg, obs.err, e.sum, e.cout, e.neg, e.err);
            end
            total++;
            if (cyc != ND + 1 || bcnt != ND) begin
                bad++;
                $display("FAIL add_latency act done_at=%0d busy=%0d req done_at=%0d busy=%0d",
                         cyc, bcnt, ND + 1, ND);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || sum !== e.sum) begin
                bad++;
                $display("FAIL add_hold act done=%b sum=%h req done=0 sum=%h", done, sum, e.sum);
            end
        end
    endtask

    task automatic test_sub();
        logic [15:0] xa[3] = '{16'h5000, 16'h1234, 16'h4321};
        logic [15:0] xb[3] = '{16'h1234, 16'h5000, 16'h4321};
        exp_t fixed[3] = '{{16'h3766, 1'b1, 1'b0, 1'b0},
                           {16'h6234, 1'b0, 1'b1, 1'b0},
                           {16'h0000, 1'b1, 1'b0, 1'b0}};
        for (int n = 0; n < 9; n++) begin
            logic [15:0] x, y;
            exp_t e, obs;
            int cyc, bcnt;
            bit to;
            if (n < 3) begin
                x = xa[n]; y = xb[n]; e = fixed[n];
            end else begin
                x = int2bcd(int'($urandom_range(0, 9999)));
                y = int2bcd(int'($urandom_range(0, 9999)));
                e = model(x, y, 1'b1, 1'b0);
            end
            sb.push_back(e);
            // cin=1 must be ignored in subtract mode
            drive_start(x, y, 1'b1, 1'b1);
            wait_done(cyc, bcnt, to);
            total++;
            if (to) begin
                bad++;
                $display("FAIL sub_timeout op=%0d", n);
                void'(sb.pop_front());
                continue;
            end
            e   = sb.pop_front();
            obs = {sum, cout, neg, err};
            if (obs !== e) begin
                bad++;
                $display("FAIL sub_result a=%h b=%h act=%h/%b/%b/%b req=%h/%b/%b/%b",
                         x, y, obs.sum, obs.cout, obs.neg, obs.err, e.sum, e.cout, e.neg, e.err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_invalid();
        logic [15:0] xa[2] = '{16'h12A4, 16'h0000};
        logic [15:0] xb[2] = '{16'h0000, 16'h00F0};
        logic        xs[2] = '{1'b0, 1'b1};
        exp_t fixed[2] = '{{16'h1304, 1'b0, 1'b0, 1'b1},
                           {16'h0010, 1'b1, 1'b0, 1'b1}};
        for (int n = 0; n < 2; n++) begin
            exp_t e, obs;
            int cyc, bcnt;
            bit to;
            sb.push_back(fixed[n]);
            drive_start(xa[n], xb[n], xs[n], 1'b0);
            wait_done(cyc, bcnt, to);
            total++;
            if (to) begin
                bad++;
                $display("FAIL invalid_timeout op=%0d", n);
                void'(sb.pop_front());
                continue;
            end
            e   = sb.pop_front();
            obs = {sum, cout, neg, err};
            if (obs !== e) begin
                bad++;
                $display("FAIL invalid_result op=%0d act=%h/%b/%b/%b req=%h/%b/%b/%b",
                         n, obs.sum, obs.cout, obs.neg, obs.err, e.sum, e.cout, e.neg, e.err);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        exp_t e, obs;
        int cyc, bcnt, pulses;
        bit to;
        sb.push_back(model(16'h2468, 16'h1357, 1'b0, 1'b1));
        drive_start(16'h2468, 16'h1357, 1'b0, 1'b1);
        // change operands and re-pulse start mid-run
        a = 16'h9999; b = 16'h9999; sub = 1'b1; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, bcnt, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL ignore_timeout");
            void'(sb.pop_front());
        end else begin
            e   = sb.pop_front();
            obs = {sum, cout, neg, err};
            if (obs !== e) begin
                bad++;
                $display("FAIL ignore_result act=%h/%b/%b/%b req=%h/%b/%b/%b",
                         obs.sum, obs.cout, obs.neg, obs.err, e.sum, e.cout, e.neg, e.err);
            end
        end
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_extra act pulses=%0d busy=%b req pulses=0 busy=0", pulses, busy);
        end
    endtask

    task automatic test_midrst();
        exp_t e, obs;
        int cyc, bcnt, pulses;
        bit to;
        sb.push_back(model(16'h1111, 16'h1111, 1'b0, 1'b0));
        drive_start(16'h1111, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        total++;
        if ({sum, cout, neg, err, busy, done} !== 21'd0) begin
            bad++;
            $display("FAIL midrst_clear act=%h req=0", {sum, cout, neg, err, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL midrst_nodone act active_cycles=%0d req=0", pulses);
        end
        sb.push_back(model(16'h0789, 16'h0456, 1'b0, 1'b0));
        drive_start(16'h0789, 16'h0456, 1'b0, 1'b0);
        wait_done(cyc, bcnt, to);
        total++;
        if (to) begin
            bad++;
            $display("FAIL midrst_timeout");
            void'(sb.pop_front());
        end else begin
            e   = sb.pop_front();
            obs = {sum, cout, neg, err};
            if (obs !== e) begin
                bad++;
                $display("FAIL midrst_fresh act=%h/%b req=%h/%b", obs.sum, obs.cout, e.sum, e.cout);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e, obs;
        int cyc, bcnt;
        bit to;
        @(negedge clk);
        a = 16'h0505; b = 16'h0606; sub = 1'b0; cin = 1'b0; start = 1'b1;
        sb.push_back(model(16'h0505, 16'h0606, 1'b0, 1'b0));
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            wait_done(cyc, bcnt, to);
            total++;
            if (to) begin
                bad++;
                $display("FAIL b2b_timeout op=%0d", n);
                void'(sb.pop_front());
                break;
            end
            e   = sb.pop_front();
            obs = {sum, cout, neg, err};
            if (obs !== e || cyc != ND + 1) begin
                bad++;
                $display("FAIL b2b_result op=%0d act=%h/%b/%b done_at=%0d req=%h/%b/%b done_at=%0d",
                         n, obs.sum, obs.cout, obs.neg, cyc, e.sum, e.cout, e.neg, ND + 1);
            end
            if (n == 0) begin
                // start still high: skipped in DONE, accepted once back in IDLE
                a = 16'h0100; b = 16'h0250; sub = 1'b1;
                sb.push_back(model(16'h0100, 16'h0250, 1'b1, 1'b0));
                @(negedge clk);
                total++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_gap act done=%b busy=%b req done=0 busy=0", done, busy);
                end
                @(negedge clk);
                start = 1'b0;
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_accept act busy=%b req busy=1", busy);
                end
            end
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_invalid();
        test_ignore_start();
        test_midrst();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
